// File: rtl/codec_sample_scheduler.sv
// codec_sample_scheduler
//   Feeds 16-bit audio samples to codecInterface. Two producers (A: CPU write
//   path, B: DMA/tone path) share one sample FIFO through a round-robin
//   arbiter. On every codec word completion (rising wordSent) the next sample
//   is popped, presented on dataOut and strobed with sendData. An empty FIFO
//   sends silence (0) and bumps a saturating underrun counter.
//
// Ports
//   clock, reset              system clock (posedge), async active-high reset
//   enable                    1 = schedule samples to the codec
//   flush                     synchronous clear of the FIFO contents
//   srcAData/srcAValid/srcAReady  source A sample channel
//   srcBData/srcBValid/srcBReady  source B sample channel
//   wordSent                  level from codecInterface, rises once per word
//   dataOut, sendData         sample and strobe to codecInterface
//   fifoLevel                 current FIFO occupancy (0..FIFO_DEPTH)
//   underrunCount             saturating count of silent sends
//
// Handshake: a sample moves from a source when srcXValid and srcXReady are
// both high in the same cycle. Ready is combinational, is only raised for a
// source that is offering (valid), never for both sources at once, and is
// held low while reset or flush is high or the FIFO is full.
module codec_sample_scheduler #(
   parameter int DATA_WIDTH        = 16,
   parameter int FIFO_DEPTH        = 8,
   parameter int SEND_PULSE_CYCLES = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          flush,
   input  logic [DATA_WIDTH-1:0]         srcAData,
   input  logic                          srcAValid,
   output logic                          srcAReady,
   input  logic [DATA_WIDTH-1:0]         srcBData,
   input  logic                          srcBValid,
   output logic                          srcBReady,
   input  logic                          wordSent,
   output logic [DATA_WIDTH-1:0]         dataOut,
   output logic                          sendData,
   output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
   output logic [15:0]                   underrunCount
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = (SEND_PULSE_CYCLES > 1) ? $clog2(SEND_PULSE_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, PULSE, WAIT} state_t;

   state_t                 state;
   logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic [LW-1:0]          level;
   logic                   rr_last_b;   // 1: B won the last transfer, so A is favoured
   logic                   wordsent_q;
   logic                   pending;
   logic [CW-1:0]          pulse_cnt;
   logic [DATA_WIDTH-1:0]  data_q;
   logic                   send_q;
   logic [15:0]            underrun_count;

   logic                   fifo_full, fifo_empty, can_push, push, pop;
   logic                   word_edge, pulse_last, fetch;
   logic [DATA_WIDTH-1:0]  push_data;

   assign fifo_full  = (level == LW'(FIFO_DEPTH));
   assign fifo_empty = (level == '0);
   assign can_push   = ~reset & ~fifo_full & ~flush;

   // Round robin: a lone offer is always taken; with both offering, the
   // source that did not win the last transfer goes first.
   assign srcAReady = can_push & srcAValid & (~srcBValid | rr_last_b);
   assign srcBReady = can_push & srcBValid & (~srcAValid | ~rr_last_b);
   assign push      = srcAReady | srcBReady;
   assign push_data = srcAReady ? srcAData : srcBData;

   assign word_edge  = wordSent & ~wordsent_q;
   assign pulse_last = (pulse_cnt == CW'(SEND_PULSE_CYCLES - 1));

   // The sample is fetched on the clock that enters LOAD, so dataOut is
   // already stable for the whole LOAD cycle before sendData rises. A pending
   // or fresh edge at the end of a pulse goes straight back to LOAD.
   assign fetch = enable & ((state == IDLE) |
                            ((state == WAIT)  & (word_edge | pending)) |
                            ((state == PULSE) & pulse_last & (word_edge | pending)));
   assign pop   = fetch & ~flush & ~fifo_empty;

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         rr_last_b <= 1'b1;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr    <= wr_ptr + AW'(1);
            rr_last_b <= srcBReady;
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         data_q         <= '0;
         send_q         <= 1'b0;
         pending        <= 1'b0;
         pulse_cnt      <= '0;
         underrun_count <= '0;
         wordsent_q     <= 1'b0;
      end else begin
         wordsent_q <= wordSent;
         if (!enable) begin
            state   <= IDLE;
            send_q  <= 1'b0;
            pending <= 1'b0;
         end else if (fetch) begin
            state   <= LOAD;
            send_q  <= 1'b0;
            pending <= 1'b0;
            if (flush || fifo_empty) data_q <= '0;
            else                     data_q <= mem[rd_ptr];
            if (!flush && fifo_empty && underrun_count != 16'hFFFF)
               underrun_count <= underrun_count + 16'd1;
         end else begin
            case (state)
               IDLE: state <= IDLE;
               LOAD: begin
                  // A flush here discards the sample already taken.
                  if (flush) data_q <= '0;
                  if (word_edge) pending <= 1'b1;
                  send_q    <= 1'b1;
                  pulse_cnt <= '0;
                  state     <= PULSE;
               end
               PULSE: begin
                  if (word_edge) pending <= 1'b1;
                  if (pulse_last) begin
                     send_q <= 1'b0;
                     state  <= WAIT;
                  end else begin
                     pulse_cnt <= pulse_cnt + CW'(1);
                  end
               end
               WAIT:    send_q <= 1'b0;
               default: state  <= IDLE;
            endcase
         end
      end
   end

   assign dataOut       = data_q;
   assign sendData      = send_q;
   assign fifoLevel     = level;
   assign underrunCount = underrun_count;

endmodule

// File: tb/tb_codec_sample_scheduler.sv
module tb_codec_sample_scheduler;
   localparam int DW    = 16;
   localparam int DEPTH = 8;
   localparam int PULSE = 4;

   logic          clock = 1'b0;
   logic          reset, enable, flush, wordSent;
   logic [DW-1:0] srcAData, srcBData, dataOut;
   logic          srcAValid, srcBValid, srcAReady, srcBReady, sendData;
   logic [3:0]    fifoLevel;
   logic [15:0]   underrunCount;

   int            pass_cnt  = 0;
   int            check_cnt = 0;
   logic [DW-1:0] exp_q[$];
   logic [15:0]   exp_underrun = '0;

   codec_sample_scheduler #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SEND_PULSE_CYCLES(PULSE)) dut (
      .clock(clock), .reset(reset), .enable(enable), .flush(flush),
      .srcAData(srcAData), .srcAValid(srcAValid), .srcAReady(srcAReady),
      .srcBData(srcBData), .srcBValid(srcBValid), .srcBReady(srcBReady),
      .wordSent(wordSent), .dataOut(dataOut), .sendData(sendData),
      .fifoLevel(fifoLevel), .underrunCount(underrunCount)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish, got running want done");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Offer one sample from a single source; it must be accepted that cycle.
   task automatic push_one(input bit use_b, input logic [DW-1:0] v);
      if (use_b) begin srcBValid = 1'b1; srcBData = v; end
      else       begin srcAValid = 1'b1; srcAData = v; end
      #1;
      check_cnt++;
      if ((use_b ? srcBReady : srcAReady) !== 1'b1)
         $display("FAIL push_ready: got %b want 1 (src %0d)", use_b ? srcBReady : srcAReady, use_b);
      else pass_cnt++;
      tick();
      srcAValid = 1'b0;
      srcBValid = 1'b0;
      exp_q.push_back(v);
   endtask

   task automatic start_send(input bit via_enable);
      if (via_enable) begin
         enable = 1'b1;
         tick();
      end else begin
         wordSent = 1'b1;
         tick();
         wordSent = 1'b0;
      end
   endtask

   // Called one clock after the fetch: checks sample, latency, pulse width.
   task automatic finish_send(input string tag);
      logic [DW-1:0] exp;
      int n;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      else begin
         exp = '0;
         if (exp_underrun != 16'hFFFF) exp_underrun++;
      end
      check_cnt++;
      if (dataOut !== exp) $display("FAIL %s_data: got %h want %h", tag, dataOut, exp);
      else pass_cnt++;
      check_cnt++;
      if (sendData !== 1'b0) $display("FAIL %s_early: sendData got %b want 0", tag, sendData);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (sendData !== 1'b1) $display("FAIL %s_latency: sendData got %b want 1", tag, sendData);
      else pass_cnt++;
      n = 0;
      while (sendData === 1'b1 && n < 20) begin
         n++;
         tick();
      end
      check_cnt++;
      if (n != PULSE) $display("FAIL %s_width: got %0d clks want %0d", tag, n, PULSE);
      else pass_cnt++;
      check_cnt++;
      if (dataOut !== exp) $display("FAIL %s_hold: got %h want %h", tag, dataOut, exp);
      else pass_cnt++;
      check_cnt++;
      if (underrunCount !== exp_underrun)
         $display("FAIL %s_underrun: got %0d want %0d", tag, underrunCount, exp_underrun);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; flush = 1'b0; wordSent = 1'b0;
      srcAValid = 1'b1; srcBValid = 1'b1; srcAData = '0; srcBData = '0;
      #2;
      check_cnt++;
      if ({sendData, dataOut, fifoLevel, underrunCount} !== '0)
         $display("FAIL reset_outputs: got %b %h %0d %0d want all zero", sendData, dataOut, fifoLevel, underrunCount);
      else pass_cnt++;
      tick(); tick();
      check_cnt++;
      if ({srcAReady, srcBReady} !== 2'b00)
         $display("FAIL reset_ready: got %b%b want 00", srcAReady, srcBReady);
      else pass_cnt++;
      reset = 1'b0; srcAValid = 1'b0; srcBValid = 1'b0;
      tick();
   endtask

   task automatic test_arbitration();
      int a_n = 0, b_n = 0;
      bit exp_a;
      srcAValid = 1'b1; srcBValid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         srcAData = 16'hA000 + 16'(a_n);
         srcBData = 16'hB000 + 16'(b_n);
         #1;
         exp_a = (i % 2 == 0);
         check_cnt++;
         if ({srcAReady, srcBReady} !== {exp_a, !exp_a})
            $display("FAIL arb_order %0d: got %b%b want %b%b", i, srcAReady, srcBReady, exp_a, !exp_a);
         else pass_cnt++;
         if (exp_a) begin exp_q.push_back(srcAData); a_n++; end
         else       begin exp_q.push_back(srcBData); b_n++; end
         tick();
         check_cnt++;
         if (fifoLevel !== 4'(i + 1)) $display("FAIL arb_level %0d: got %0d want %0d", i, fifoLevel, i + 1);
         else pass_cnt++;
      end
      srcAValid = 1'b0; srcBValid = 1'b0;
   endtask

   task automatic test_flush();
      push_one(1'b0, 16'h5555);
      check_cnt++;
      if (fifoLevel !== 4'd5) $display("FAIL flush_pre_level: got %0d want 5", fifoLevel);
      else pass_cnt++;
      srcAValid = 1'b1; srcBValid = 1'b1; flush = 1'b1;
      #1;
      check_cnt++;
      if ({srcAReady, srcBReady} !== 2'b00)
         $display("FAIL flush_ready: got %b%b want 00", srcAReady, srcBReady);
      else pass_cnt++;
      tick();
      flush = 1'b0; srcAValid = 1'b0; srcBValid = 1'b0;
      check_cnt++;
      if (fifoLevel !== 4'd0) $display("FAIL flush_level: got %0d want 0", fifoLevel);
      else pass_cnt++;
      exp_q.delete();
   endtask

   task automatic test_basic();
      push_one(1'b0, 16'h1234);
      push_one(1'b0, 16'h5678);
      start_send(1'b1);
      finish_send("basic_prime");
      start_send(1'b0);
      finish_send("basic_word");
      check_cnt++;
      if (fifoLevel !== 4'd0) $display("FAIL basic_level: got %0d want 0", fifoLevel);
      else pass_cnt++;
   endtask

   task automatic test_full();
      int guard = 0;
      enable = 1'b0;
      tick();
      for (int i = 0; i < DEPTH; i++) push_one(i[0], 16'hC000 + 16'(i));
      check_cnt++;
      if (fifoLevel !== 4'(DEPTH)) $display("FAIL full_level: got %0d want %0d", fifoLevel, DEPTH);
      else pass_cnt++;
      srcAValid = 1'b1; srcBValid = 1'b1;
      #1;
      check_cnt++;
      if ({srcAReady, srcBReady} !== 2'b00)
         $display("FAIL full_ready: got %b%b want 00", srcAReady, srcBReady);
      else pass_cnt++;
      srcAValid = 1'b0; srcBValid = 1'b0;
      start_send(1'b1);
      finish_send("full_prime");
      // Push and pop on the same clock: level must not move.
      srcAValid = 1'b1; srcAData = 16'hD00D; wordSent = 1'b1;
      #1;
      check_cnt++;
      if (srcAReady !== 1'b1) $display("FAIL full_pushpop_ready: got %b want 1", srcAReady);
      else pass_cnt++;
      tick();
      srcAValid = 1'b0; wordSent = 1'b0;
      exp_q.push_back(16'hD00D);
      check_cnt++;
      if (fifoLevel !== 4'(DEPTH - 1)) $display("FAIL full_pushpop_level: got %0d want %0d", fifoLevel, DEPTH - 1);
      else pass_cnt++;
      finish_send("full_pushpop");
      while (exp_q.size() > 0 && guard < 20) begin
         start_send(1'b0);
         finish_send("drain");
         guard++;
      end
      check_cnt++;
      if (fifoLevel !== 4'd0) $display("FAIL drain_level: got %0d want 0", fifoLevel);
      else pass_cnt++;
   endtask

   task automatic test_underrun();
      enable = 1'b0;
      tick();
      start_send(1'b1);
      finish_send("underrun_prime");
      for (int i = 0; i < 3; i++) begin
         start_send(1'b0);
         finish_send("underrun_word");
      end
      check_cnt++;
      if (underrunCount !== 16'd4) $display("FAIL underrun_total: got %0d want 4", underrunCount);
      else pass_cnt++;
      force dut.underrun_count = 16'hFFFE;
      #1;
      release dut.underrun_count;
      exp_underrun = 16'hFFFE;
      for (int i = 0; i < 2; i++) begin
         start_send(1'b0);
         finish_send("underrun_sat");
      end
      check_cnt++;
      if (underrunCount !== 16'hFFFF) $display("FAIL underrun_saturate: got %h want ffff", underrunCount);
      else pass_cnt++;
   endtask

   task automatic test_pending();
      int n = 0, rises = 0;
      logic prev;
      push_one(1'b0, 16'h1111);
      push_one(1'b1, 16'h2222);
      wordSent = 1'b1;
      tick();
      wordSent = 1'b0;
      void'(exp_q.pop_front());
      check_cnt++;
      if (dataOut !== 16'h1111) $display("FAIL pend_first: got %h want 1111", dataOut);
      else pass_cnt++;
      tick(); tick();
      wordSent = 1'b1;
      tick();
      wordSent = 1'b0;
      while (sendData === 1'b1 && n < 20) begin n++; tick(); end
      void'(exp_q.pop_front());
      check_cnt++;
      if (dataOut !== 16'h2222) $display("FAIL pend_reload: got %h want 2222", dataOut);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (sendData !== 1'b1) $display("FAIL pend_immediate: sendData got %b want 1", sendData);
      else pass_cnt++;
      n = 0;
      while (sendData === 1'b1 && n < 20) begin n++; tick(); end
      // Held level must give exactly one send.
      push_one(1'b0, 16'h3333);
      prev = sendData;
      wordSent = 1'b1;
      for (int i = 0; i < 24; i++) begin
         if (i == 10) wordSent = 1'b0;
         tick();
         if (sendData === 1'b1 && prev === 1'b0) rises++;
         prev = sendData;
      end
      void'(exp_q.pop_front());
      check_cnt++;
      if (rises != 1) $display("FAIL held_sends: got %0d want 1", rises);
      else pass_cnt++;
      check_cnt++;
      if (dataOut !== 16'h3333) $display("FAIL held_data: got %h want 3333", dataOut);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_pulse();
      push_one(1'b0, 16'h4001);
      push_one(1'b0, 16'h4002);
      push_one(1'b0, 16'h4003);
      wordSent = 1'b1;
      tick();
      wordSent = 1'b0;
      tick();
      check_cnt++;
      if (sendData !== 1'b1) $display("FAIL midrst_pulse: sendData got %b want 1", sendData);
      else pass_cnt++;
      reset = 1'b1;
      #1;
      check_cnt++;
      if ({sendData, fifoLevel, underrunCount, dataOut} !== '0)
         $display("FAIL midrst_async: got %b %0d %0d %h want all zero", sendData, fifoLevel, underrunCount, dataOut);
      else pass_cnt++;
      enable = 1'b0;
      tick();
      reset = 1'b0;
      exp_q.delete();
      exp_underrun = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_arbitration();
      test_flush();
      test_basic();
      test_full();
      test_underrun();
      test_pending();
      test_reset_mid_pulse();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end
endmodule
